// File: rtl/onedcfnn_axil_pkg.sv
// Shared definitions for the onedcfnn AXI4-Lite register bank:
// response codes, write/read FSM state encodings and a constant clog2.
package onedcfnn_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WrIdle,
        WrCommit,
        WrResp
    } wr_state_e;

    typedef enum logic {
        RdIdle,
        RdData
    } rd_state_e;

    // Ceiling log2, usable in parameter expressions.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/onedcfnn_axil_reg.sv
// One read/write control register with byte-strobe write enables.
module onedcfnn_axil_reg
    import onedcfnn_axil_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            we_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic [DW/8-1:0] wstrb_i,
    output logic [DW-1:0]   q_o
);

    logic [DW-1:0] q_q;

    // Synchronous reset; on write enable, update only the strobed bytes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else if (we_i) begin
            for (int unsigned b = 0; b < DW / 8; b++) begin
                if (wstrb_i[b]) begin
                    q_q[b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/onedcfnn_axil_regbank.sv
// AXI4-Lite slave register bank: NUM_RW control registers followed by NUM_RO
// status shadows in the word address map. Independent write and read FSMs.
// Optional: define ONEDCFNN_AXIL_SLVERR_EN to answer SLVERR for writes to
// RO/unmapped words and for unmapped reads (otherwise every response is OKAY).
module onedcfnn_axil_regbank
    import onedcfnn_axil_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned NUM_RW             = 8,
    parameter int unsigned NUM_RO             = 4,
    parameter int unsigned C_S_AXI_ADDR_WIDTH =
        clog2(NUM_RW + NUM_RO) + clog2(C_S_AXI_DATA_WIDTH / 8)
) (
    input  logic                                 ACLK,
    input  logic                                 ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
    input  logic [2:0]                           S_AXI_AWPROT,
    input  logic                                 S_AXI_AWVALID,
    output logic                                 S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
    input  logic                                 S_AXI_WVALID,
    output logic                                 S_AXI_WREADY,
    output logic [1:0]                           S_AXI_BRESP,
    output logic                                 S_AXI_BVALID,
    input  logic                                 S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
    input  logic [2:0]                           S_AXI_ARPROT,
    input  logic                                 S_AXI_ARVALID,
    output logic                                 S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
    output logic [1:0]                           S_AXI_RRESP,
    output logic                                 S_AXI_RVALID,
    input  logic                                 S_AXI_RREADY,
    output logic [NUM_RW*C_S_AXI_DATA_WIDTH-1:0] ctrl_o,
    output logic [NUM_RW-1:0]                    wr_pulse_o,
    input  logic [NUM_RO*C_S_AXI_DATA_WIDTH-1:0] status_i
);

    localparam int unsigned DW   = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW   = DW / 8;
    localparam int unsigned OFS  = clog2(SW);
    localparam int unsigned IW   = C_S_AXI_ADDR_WIDTH - OFS;
    localparam int unsigned RO_N = (NUM_RO > 0) ? NUM_RO : 1;
`ifdef ONEDCFNN_AXIL_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    // Write path state
    wr_state_e         wr_state_q, wr_state_d;
    logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic              awready_q, awready_d, wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [IW-1:0]     wr_idx_q, wr_idx_d;
    logic [DW-1:0]     wr_data_q, wr_data_d;
    logic [SW-1:0]     wr_strb_q, wr_strb_d;
    logic              aw_hs, w_hs;
    logic [31:0]       wr_idx_u;
    logic [NUM_RW-1:0] wr_pulse;

    // Read path state
    rd_state_e         rd_state_q, rd_state_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DW-1:0]     rdata_q, rdata_d, rd_val;
    logic [1:0]        rresp_q, rresp_d, rd_resp;
    logic [31:0]       ar_idx_u;

    logic [DW-1:0]     rw_q [NUM_RW];
    logic [DW-1:0]     ro_q [RO_N];

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[OFS-1:0],
                         S_AXI_ARADDR[OFS-1:0]};

    assign aw_hs    = S_AXI_AWVALID && awready_q;
    assign w_hs     = S_AXI_WVALID && wready_q;
    assign wr_idx_u = 32'(wr_idx_q);
    assign ar_idx_u = 32'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:OFS]);

    // Write FSM next state: gather AW and W in any order, commit, then respond.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_idx_d   = wr_idx_q;
        wr_data_d  = wr_data_q;
        wr_strb_d  = wr_strb_q;
        unique case (wr_state_q)
            WrIdle: begin
                if (aw_hs) begin
                    wr_idx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:OFS];
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wr_data_d = S_AXI_WDATA;
                    wr_strb_d = S_AXI_WSTRB;
                    w_done_d  = 1'b1;
                end
                // Each channel is taken once; ready stays low after capture.
                awready_d = !(aw_done_q || aw_hs);
                wready_d  = !(w_done_q || w_hs);
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    wr_state_d = WrCommit;
                end
            end
            WrCommit: begin
                wr_state_d = WrResp;
                aw_done_d  = 1'b0;
                w_done_d   = 1'b0;
                bvalid_d   = 1'b1;
                bresp_d    = (SLVERR_EN && (wr_idx_u >= NUM_RW)) ? RESP_SLVERR : RESP_OKAY;
            end
            WrResp: begin
                if (S_AXI_BREADY) begin
                    wr_state_d = WrIdle;
                    bvalid_d   = 1'b0;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                end
            end
            default: wr_state_d = WrIdle;
        endcase
    end

    // Commit strobe: one RW register for the single COMMIT cycle.
    always_comb begin
        wr_pulse = '0;
        for (int unsigned i = 0; i < NUM_RW; i++) begin
            wr_pulse[i] = (wr_state_q == WrCommit) && (wr_idx_u == i);
        end
    end

    // Write FSM registers.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wr_state_q <= WrIdle;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_idx_q   <= '0;
            wr_data_q  <= '0;
            wr_strb_q  <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_idx_q   <= wr_idx_d;
            wr_data_q  <= wr_data_d;
            wr_strb_q  <= wr_strb_d;
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_rw
        onedcfnn_axil_reg #(
            .DW (DW)
        ) u_reg (
            .clk_i   (ACLK),
            .rst_ni  (ARESETN),
            .we_i    (wr_pulse[g]),
            .wdata_i (wr_data_q),
            .wstrb_i (wr_strb_q),
            .q_o     (rw_q[g])
        );
        assign ctrl_o[g*DW +: DW] = rw_q[g];
    end

    // Status shadows follow status_i every cycle.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            for (int unsigned i = 0; i < RO_N; i++) ro_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_RO; i++) ro_q[i] <= status_i[i*DW +: DW];
        end
    end

    // Read mux on the live AR address; unmapped words read as zero.
    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < NUM_RW; i++) begin
            if (ar_idx_u == i) rd_val = rw_q[i];
        end
        for (int unsigned i = 0; i < NUM_RO; i++) begin
            if (ar_idx_u == NUM_RW + i) rd_val = ro_q[i];
        end
        rd_resp = (SLVERR_EN && (ar_idx_u >= NUM_RW + NUM_RO)) ? RESP_SLVERR : RESP_OKAY;
    end

    // Read FSM next state: data is captured on the AR handshake, so a commit in
    // that same cycle is not yet visible.
    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        unique case (rd_state_q)
            RdIdle: begin
                arready_d = 1'b1;
                if (S_AXI_ARVALID && arready_q) begin
                    arready_d  = 1'b0;
                    rvalid_d   = 1'b1;
                    rdata_d    = rd_val;
                    rresp_d    = rd_resp;
                    rd_state_d = RdData;
                end
            end
            RdData: begin
                if (S_AXI_RREADY) begin
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                    rd_state_d = RdIdle;
                end
            end
            default: rd_state_d = RdIdle;
        endcase
    end

    // Read FSM registers.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            rd_state_q <= RdIdle;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign wr_pulse_o    = wr_pulse;

endmodule

// File: tb/tb_onedcfnn_axil_regbank.sv
// Scoreboard bench for onedcfnn_axil_regbank (default parameters).
module tb_onedcfnn_axil_regbank;

    localparam int NRW = 8;
    localparam int NRO = 4;
    localparam int AW  = 6;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0]      awaddr = '0, araddr = '0;
    logic               awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0]        wdata = '0;
    logic [3:0]         wstrb = '0;
    logic               awready, wready, bvalid, arready, rvalid;
    logic [1:0]         bresp, rresp;
    logic [31:0]        rdata;
    logic [NRW*32-1:0]  ctrl;
    logic [NRW-1:0]     wr_pulse;
    logic [NRO*32-1:0]  status = '0;

    onedcfnn_axil_regbank dut (
        .ACLK          (clk),
        .ARESETN       (rstn),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (3'b000),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (3'b000),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .ctrl_o        (ctrl),
        .wr_pulse_o    (wr_pulse),
        .status_i      (status)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: register contents and expected commit counts.
    logic [31:0] m_rw [NRW];
    int          exp_pulse [NRW];
    int          pulse_cnt [NRW];
    logic [1:0]  bq [$];
    logic [31:0] rq_data [$];
    logic [1:0]  rq_resp [$];

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected handshake", name);
    endfunction

    function automatic logic [1:0] err_resp();
`ifdef ONEDCFNN_AXIL_SLVERR_EN
        return 2'b10;
`else
        return 2'b00;
`endif
    endfunction

    function automatic logic [1:0] exp_bresp(input int idx);
        return (idx < NRW) ? 2'b00 : err_resp();
    endfunction

    function automatic logic [1:0] exp_rresp(input int idx);
        return (idx < NRW + NRO) ? 2'b00 : err_resp();
    endfunction

    function automatic logic [31:0] exp_read(input int idx);
        if (idx < NRW) return m_rw[idx];
        if (idx < NRW + NRO) return status[(idx-NRW)*32 +: 32];
        return 32'h0;
    endfunction

    // Monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (rstn) begin
            if (bvalid && bready) begin
                if (bq.size() == 0) fail("b_unexpected");
                else check("bresp", 64'(bresp), 64'(bq.pop_front()));
            end
            if (rvalid && rready) begin
                if (rq_data.size() == 0) fail("r_unexpected");
                else begin
                    check("rdata", 64'(rdata), 64'(rq_data.pop_front()));
                    check("rresp", 64'(rresp), 64'(rq_resp.pop_front()));
                end
            end
        end
        for (int i = 0; i < NRW; i++) if (wr_pulse[i]) pulse_cnt[i]++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
    task automatic axi_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                             input int lead, input int b_hold);
        int aw_cyc, w_cyc, last, got;
        logic [1:0] er;
        er = exp_bresp(idx);
        bq.push_back(er);
        aw_cyc = -1;
        w_cyc = -1;
        fork
            begin
                if (lead < 0) tick(-lead);
                wdata = data;
                wstrb = strb;
                wvalid = 1'b1;
                for (int t = 0; t < 50; t++) begin
                    @(negedge clk);
                    if (wready) begin
                        w_cyc = cyc;
                        break;
                    end
                    @(posedge clk);
                    #1;
                end
                @(posedge clk);
                #1;
                wvalid = 1'b0;
            end
            begin
                if (lead > 0) tick(lead);
                awaddr = AW'(idx * 4);
                awvalid = 1'b1;
                for (int t = 0; t < 50; t++) begin
                    @(negedge clk);
                    if (awready) begin
                        aw_cyc = cyc;
                        break;
                    end
                    @(posedge clk);
                    #1;
                end
                @(posedge clk);
                #1;
                awvalid = 1'b0;
            end
        join
        if (aw_cyc < 0 || w_cyc < 0) begin
            fail("wr_addr_data_handshake");
            void'(bq.pop_back());
            return;
        end
        last = (aw_cyc > w_cyc) ? aw_cyc : w_cyc;
        got = -1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bvalid) begin
                got = cyc;
                break;
            end
        end
        if (got < 0) begin
            fail("bvalid_wait");
            void'(bq.pop_back());
            return;
        end
        check("b_latency", 64'(got - last), 64'd2);
        for (int k = 0; k < b_hold; k++) begin
            @(negedge clk);
            check("bvalid_hold", 64'(bvalid), 64'd1);
            check("bresp_hold", 64'(bresp), 64'(er));
        end
        @(posedge clk);
        #1;
        bready = 1'b1;
        @(posedge clk);
        #1;
        bready = 1'b0;
        if (idx < NRW) begin
            for (int b = 0; b < 4; b++) if (strb[b]) m_rw[idx][b*8 +: 8] = data[b*8 +: 8];
            exp_pulse[idx]++;
        end
    endtask

    task automatic axi_read(input int idx, input int r_hold, input bit chk_sc);
        int hs;
        hs = -1;
        araddr = AW'(idx * 4);
        arvalid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (arready) begin
                hs = cyc;
                rq_data.push_back(exp_read(idx));
                rq_resp.push_back(exp_rresp(idx));
                if (chk_sc) check("same_cycle_commit", 64'(wr_pulse[1]), 64'd1);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        if (hs < 0) begin
            fail("arready_wait");
            return;
        end
        @(negedge clk);
        check("r_latency", 64'(rvalid), 64'd1);
        for (int k = 0; k < r_hold; k++) begin
            @(negedge clk);
            check("rvalid_hold", 64'(rvalid), 64'd1);
        end
        @(posedge clk);
        #1;
        rready = 1'b1;
        @(posedge clk);
        #1;
        rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        for (int i = 0; i < NRW; i++) begin
            m_rw[i] = '0;
            exp_pulse[i] = 0;
            pulse_cnt[i] = 0;
        end
        status = {32'h0, 32'h0, 32'h0, 32'hDEADBEEF};
        rstn = 1'b0;
        tick(2);
        @(negedge clk);
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_ctrl", 64'(|ctrl), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("awready_before_release", 64'(awready), 64'd0);
        tick(1);
        @(negedge clk);
        check("ready_after_release", 64'({awready, wready, arready}), 64'b111);
        tick(1);

        // Baseline write/readback.
        for (int i = 0; i < 4; i++) axi_write(i, 32'(i + 1), 4'hF, 0, 0);
        for (int i = 0; i < 4; i++) axi_read(i, 0, 1'b0);
        for (int i = 0; i < NRW; i++) check("pulse_once", 64'(pulse_cnt[i]), (i < 4) ? 64'd1 : 64'd0);

        // Byte strobes.
        axi_write(0, 32'hAABBCCDD, 4'hF, 0, 0);
        axi_write(0, 32'h11223344, 4'b0101, 0, 0);
        axi_read(0, 1, 1'b0);
        check("strobe_ctrl", 64'(ctrl[31:0]), 64'hAA22CC44);

        // W three cycles ahead of AW, BREADY held off five cycles.
        axi_write(2, 32'h5A5A0003, 4'hF, 3, 5);

        // RO shadow, write to RO, unmapped read.
        axi_read(8, 0, 1'b0);
        axi_write(8, 32'h12345678, 4'hF, 0, 0);
        axi_read(8, 0, 1'b0);
        axi_read(12, 0, 1'b0);

        // AR handshake lands in the COMMIT cycle of a write to the same word.
        fork
            axi_write(1, 32'h9, 4'hF, 0, 0);
            begin
                tick(1);
                axi_read(1, 0, 1'b1);
            end
        join
        check("same_cycle_old", 64'(m_rw[1]), 64'h9);
        axi_read(1, 0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < NRO; i++) status[i*32 +: 32] = $urandom;
        tick(2);
        for (int n = 0; n < 40; n++) begin
            int idx;
            idx = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1)
                axi_write(idx, $urandom, 4'($urandom_range(0, 15)),
                          int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
            else
                axi_read(idx, int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset between AW and W handshakes.
        status = '0;
        awaddr = AW'(3 * 4);
        awvalid = 1'b1;
        ok = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (awready) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        if (!ok) fail("rst_test_aw");
        tick(1);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_outputs", 64'({awready, wready, arready, bvalid, rvalid}), 64'd0);
        check("midrst_pulse", 64'(wr_pulse), 64'd0);
        tick(1);
        rstn = 1'b1;
        @(negedge clk);
        check("midrst_ready_low", 64'({awready, wready, arready}), 64'd0);
        tick(1);
        @(negedge clk);
        check("midrst_ready_high", 64'({awready, wready, arready}), 64'b111);
        tick(1);
        for (int i = 0; i < NRW; i++) m_rw[i] = '0;
        for (int i = 0; i < NRW + NRO; i++) axi_read(i, 0, 1'b0);
        axi_write(3, 32'hCAFEF00D, 4'hF, 0, 1);
        axi_read(3, 0, 1'b0);

        tick(2);
        for (int i = 0; i < NRW; i++) begin
            check("final_ctrl", 64'(ctrl[i*32 +: 32]), 64'(m_rw[i]));
            check("final_pulses", 64'(pulse_cnt[i]), 64'(exp_pulse[i]));
        end
        check("bq_empty", 64'(bq.size()), 64'd0);
        check("rq_empty", 64'(rq_data.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
